fc_result_reader: RTL and testbench

- Consumer end of the fully-connected stage's result interface.
- Captures the `output_nodes` fp16 logits when the FC stage signals done, then runs a serial argmax over them, one node per cycle.
- Presents the winning class to downstream logic (alarm/UART) over a valid/ready handshake.
- Maintains a consecutive-detection persistence counter that drives the human-on-railway alarm.

---
 rtl/fc_result_reader_pkg.sv | 44 ++++
 rtl/fc_result_reader_if.sv | 11 +
 rtl/fc_result_reader_fp16_max_cmp.sv | 15 +
 rtl/fc_result_reader.sv | 193 +++++++++++++++++++
 tb/tb_fc_result_reader.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_result_reader_pkg.sv
// Shared types, constants and the fp16 ordering helper for fc_result_reader.
package fc_result_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam logic [4:0] FP16_EXP_MAX = 5'h1F;
    localparam int         FP16_W       = 16;

    // NaN: exponent all ones with a non-zero mantissa.
    function automatic logic fp16_is_nan(input logic [FP16_W-1:0] v);
        return (v[14:10] == FP16_EXP_MAX) && (v[9:0] != 10'h000);
    endfunction

    // Monotonic unsigned key for sign-magnitude ordering; both zeros map to one key.
    function automatic logic [FP16_W-1:0] fp16_key(input logic [FP16_W-1:0] v);
        logic [FP16_W-1:0] key;
        if (v[14:0] == 15'h0000) begin
            key = 16'h8000;
        end else if (v[15]) begin
            key = {1'b0, ~v[14:0]};
        end else begin
            key = {1'b1, v[14:0]};
        end
        return key;
    endfunction

    // a strictly greater than b; a NaN is never greater, a NaN b loses to any non-NaN a.
    function automatic logic fp16_gt(input logic [FP16_W-1:0] a, input logic [FP16_W-1:0] b);
        logic gt;
        if (fp16_is_nan(a)) begin
            gt = 1'b0;
        end else if (fp16_is_nan(b)) begin
            gt = 1'b1;
        end else begin
            gt = (fp16_key(a) > fp16_key(b));
        end
        return gt;
    endfunction

endpackage

// File: rtl/fc_result_reader_if.sv
// Result handshake between fc_result_reader (master) and its consumer (slave).
interface fc_result_if #(
    parameter int CLS_W = 4
);
    logic [CLS_W-1:0] result_class;
    logic             result_valid;
    logic             result_ready;

    modport master (output result_class, output result_valid, input result_ready);
    modport slave  (input result_class, input result_valid, output result_ready);
endinterface

// File: rtl/fc_result_reader_fp16_max_cmp.sv
// Combinational fp16 "a strictly greater than b" comparator used by the argmax scan.
module fp16_max_cmp
    import fc_result_pkg::*;
(
    input  logic [FP16_W-1:0] a,
    input  logic [FP16_W-1:0] b,
    output logic              a_gt_b
);

    // Ordering with NaN and signed-zero handling lives in the package helper.
    always_comb begin
        a_gt_b = fp16_gt(a, b);
    end

endmodule

// File: rtl/fc_result_reader.sv
// fc_result_reader: captures FC logits on fc_done rising edge, serial argmax,
// presents the class over a valid/ready handshake and tracks human persistence.
// Optional macro FC_RESULT_STATS_EN adds saturating frame_count/human_count outputs.
module fc_result_reader
    import fc_result_pkg::*;
#(
    parameter int datawidth      = 16,
    parameter int output_nodes   = 2,
    parameter int HUMAN_IDX      = 1,
    parameter int PERSIST_FRAMES = 3,
    parameter int CLS_W          = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [datawidth*output_nodes-1:0] fc_output_data,
    input  logic                              fc_done,
    fc_result_if.master                       result_bus,
    output logic                              human_alarm,
    output logic                              overrun,
    output logic                              busy
`ifdef FC_RESULT_STATS_EN
    ,
    output logic [15:0]                       frame_count,
    output logic [15:0]                       human_count
`endif
);

    localparam int               CNT_W       = $clog2(PERSIST_FRAMES + 1);
    localparam logic [CNT_W-1:0] PERSIST_MAX = CNT_W'(PERSIST_FRAMES);
    localparam logic [CLS_W-1:0] LAST_PTR    = CLS_W'(output_nodes - 1);
    localparam logic [CLS_W-1:0] HUMAN_CLS   = CLS_W'(HUMAN_IDX);

    state_t                            state_r, state_next_s;
    logic                              done_q_r;
    logic                              done_rise_s;
    logic [datawidth*output_nodes-1:0] buf_r;
    logic [CLS_W-1:0]                  ptr_r;
    logic [CLS_W-1:0]                  best_idx_r;
    logic [FP16_W-1:0]                 best_val_r;
    logic [FP16_W-1:0]                 cur_logit_s;
    logic                              gt_s;
    logic                              result_valid_r;
    logic [CLS_W-1:0]                  result_class_r;
    logic                              handshake_s;
    logic [CNT_W-1:0]                  count_r, count_next_s;
    logic                              alarm_r, overrun_r, busy_r;

    assign done_rise_s             = fc_done & ~done_q_r;
    assign handshake_s             = result_valid_r & result_bus.result_ready;
    assign cur_logit_s             = buf_r[int'(ptr_r)*datawidth +: FP16_W];
    assign result_bus.result_valid = result_valid_r;
    assign result_bus.result_class = result_class_r;
    assign human_alarm             = alarm_r;
    assign overrun                 = overrun_r;
    assign busy                    = busy_r;

    fp16_max_cmp u_cmp (
        .a      (cur_logit_s),
        .b      (best_val_r),
        .a_gt_b (gt_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: capture on edge, scan one node per cycle, hold until accepted.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (done_rise_s) begin
                    state_next_s = (output_nodes == 1) ? PRESENT : SCAN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SCAN: begin
                if (ptr_r == LAST_PTR) begin
                    state_next_s = PRESENT;
                end else begin
                    state_next_s = SCAN;
                end
            end
            PRESENT: begin
                if (handshake_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = PRESENT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Edge detect, overrun pulse (rise while busy drops the frame) and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q_r  <= 1'b0;
            overrun_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            done_q_r  <= fc_done;
            overrun_r <= done_rise_s & (state_r != IDLE);
            busy_r    <= (state_next_s != IDLE);
        end
    end

    // Logit capture and argmax scan; ties keep the lower index.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_r      <= {(datawidth*output_nodes){1'b0}};
            ptr_r      <= {CLS_W{1'b0}};
            best_idx_r <= {CLS_W{1'b0}};
            best_val_r <= {FP16_W{1'b0}};
        end else if (state_r == IDLE && done_rise_s) begin
            buf_r      <= fc_output_data;
            ptr_r      <= CLS_W'(1);
            best_idx_r <= {CLS_W{1'b0}};
            best_val_r <= fc_output_data[FP16_W-1:0];
        end else if (state_r == SCAN) begin
            ptr_r <= ptr_r + CLS_W'(1);
            if (gt_s) begin
                best_idx_r <= ptr_r;
                best_val_r <= cur_logit_s;
            end
        end
    end

    // Result register: raised one cycle after entering PRESENT, cleared on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid_r <= 1'b0;
            result_class_r <= {CLS_W{1'b0}};
        end else if (state_r == PRESENT && !result_valid_r) begin
            result_valid_r <= 1'b1;
            result_class_r <= best_idx_r;
        end else if (handshake_s) begin
            result_valid_r <= 1'b0;
        end
    end

    // Saturating persistence count for the accepted class.
    always_comb begin
        if (result_class_r == HUMAN_CLS) begin
            if (count_r == PERSIST_MAX) begin
                count_next_s = count_r;
            end else begin
                count_next_s = count_r + CNT_W'(1);
            end
        end else begin
            count_next_s = {CNT_W{1'b0}};
        end
    end

    // Persistence and alarm update on each accepted result.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
            alarm_r <= 1'b0;
        end else if (handshake_s) begin
            count_r <= count_next_s;
            alarm_r <= (count_next_s == PERSIST_MAX);
        end
    end

`ifdef FC_RESULT_STATS_EN
    logic [15:0] frame_count_r, human_count_r;
    assign frame_count = frame_count_r;
    assign human_count = human_count_r;

    // Saturating statistics on accepted results.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_r <= 16'h0000;
            human_count_r <= 16'h0000;
        end else if (handshake_s) begin
            if (frame_count_r != 16'hFFFF) begin
                frame_count_r <= frame_count_r + 16'h0001;
            end
            if (result_class_r == HUMAN_CLS && human_count_r != 16'hFFFF) begin
                human_count_r <= human_count_r + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fc_result_reader.sv
// Self-checking bench for fc_result_reader: directed cases plus randomized traffic
// against a frame-level behavioural model.
module tb_fc_result_reader;

    localparam int NODES   = 2;
    localparam int HUMAN   = 1;
    localparam int PERSIST = 3;

    logic              clk;
    logic              reset;
    logic [NODES*16-1:0] fc_data;
    logic              fc_done;
    logic              human_alarm, overrun, busy;
`ifdef FC_RESULT_STATS_EN
    logic [15:0]       frame_count, human_count;
`endif

    fc_result_if #(.CLS_W(4)) res_if ();

    fc_result_reader #(
        .datawidth(16), .output_nodes(NODES), .HUMAN_IDX(HUMAN),
        .PERSIST_FRAMES(PERSIST), .CLS_W(4)
    ) dut (
        .clk(clk), .reset(reset), .fc_output_data(fc_data), .fc_done(fc_done),
        .result_bus(res_if), .human_alarm(human_alarm), .overrun(overrun), .busy(busy)
`ifdef FC_RESULT_STATS_EN
        , .frame_count(frame_count), .human_count(human_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model state
    int m_dq, m_inflight, m_cnt, m_valid, m_class, m_pending, m_count, m_alarm, m_overrun;
    int m_frames, m_humans;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_nan(input logic [15:0] v);
        return (v[14:10] == 5'd31) && (v[9:0] != 10'd0);
    endfunction

    // Numeric value of an fp16 (non-NaN); infinities become huge magnitudes.
    function automatic real fp16_val(input logic [15:0] v);
        int  e;
        int  m;
        real mag;
        e = int'(v[14:10]);
        m = int'(v[9:0]);
        if (e == 31)     mag = 1.0e12;
        else if (e == 0) mag = m * (2.0 ** (-24));
        else             mag = (1.0 + m / 1024.0) * (2.0 ** (e - 15));
        return v[15] ? -mag : mag;
    endfunction

    // First index of the largest non-NaN value; 0 if all NaN.
    function automatic int model_argmax(input logic [NODES*16-1:0] d);
        int          best;
        real         bv;
        logic [15:0] v;
        best = -1;
        bv   = 0.0;
        for (int i = 0; i < NODES; i++) begin
            v = d[16*i +: 16];
            if (!is_nan(v)) begin
                if (best < 0 || fp16_val(v) > bv) begin
                    best = i;
                    bv   = fp16_val(v);
                end
            end
        end
        return (best < 0) ? 0 : best;
    endfunction

    // Frame-level model advanced once per rising clock edge.
    task automatic model_step();
        int rise, hs, was_busy;
        if (reset) begin
            m_dq = 0; m_inflight = 0; m_cnt = 0; m_valid = 0; m_class = 0;
            m_count = 0; m_alarm = 0; m_overrun = 0; m_frames = 0; m_humans = 0;
        end else begin
            rise      = (fc_done && m_dq == 0) ? 1 : 0;
            m_dq      = fc_done ? 1 : 0;
            hs        = (m_valid == 1 && res_if.result_ready) ? 1 : 0;
            was_busy  = m_inflight;
            m_overrun = (rise == 1 && was_busy == 1) ? 1 : 0;
            if (hs == 1) begin
                if (m_class == HUMAN) m_count = (m_count < PERSIST) ? m_count + 1 : PERSIST;
                else                  m_count = 0;
                m_alarm    = (m_count == PERSIST) ? 1 : 0;
                m_valid    = 0;
                m_inflight = 0;
                if (m_frames < 65535) m_frames++;
                if (m_class == HUMAN && m_humans < 65535) m_humans++;
            end else if (m_inflight == 1 && m_valid == 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1;
                    m_class = m_pending;
                end
            end
            if (rise == 1 && was_busy == 0) begin
                m_inflight = 1;
                m_cnt      = NODES;
                m_pending  = model_argmax(fc_data);
            end
        end
    endtask

    // One clock: advance model at the edge, compare all outputs 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("result_valid", 32'(res_if.result_valid), 32'(m_valid));
        check("result_class", 32'(res_if.result_class), 32'(m_class));
        check("human_alarm",  32'(human_alarm),         32'(m_alarm));
        check("overrun",      32'(overrun),             32'(m_overrun));
        check("busy",         32'(busy),                32'(m_inflight));
`ifdef FC_RESULT_STATS_EN
        check("frame_count",  32'(frame_count),         32'(m_frames));
        check("human_count",  32'(human_count),         32'(m_humans));
`endif
    endtask

    // Directed frame with ready high: checks latency and a literal class.
    task automatic run_frame(input logic [31:0] d, input int exp_cls, input string nm);
        int n;
        fc_data             = d;
        fc_done             = 1'b1;
        res_if.result_ready = 1'b1;
        cycle();
        fc_done = 1'b0;
        n = 0;
        while (!res_if.result_valid && n < 10) begin
            cycle();
            n++;
        end
        check({nm, "_latency"}, 32'(n), 32'd2);
        check({nm, "_class"}, 32'(res_if.result_class), 32'(exp_cls));
        check({nm, "_model"}, 32'(m_class), 32'(exp_cls));
        cycle();
        check({nm, "_accepted"}, 32'(res_if.result_valid), 32'd0);
    endtask

    function automatic logic [15:0] rand_logit();
        logic [15:0] v;
        case ($urandom_range(0, 9))
            0:       v = 16'h3C00;
            1:       v = 16'h4000;
            2:       v = 16'h7E00;
            3:       v = 16'hFC00;
            4:       v = 16'h7C00;
            5:       v = 16'h8000;
            6:       v = 16'h0000;
            7:       v = 16'hBC00;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        reset = 1'b1; fc_done = 1'b0; fc_data = 32'h0; res_if.result_ready = 1'b0;
        m_dq = 0; m_inflight = 0; m_cnt = 0; m_valid = 0; m_class = 0; m_pending = 0;
        m_count = 0; m_alarm = 0; m_overrun = 0; m_frames = 0; m_humans = 0;

        // pin the model on hand-computed cases
        check("pin_2_gt_1",    32'(model_argmax(32'h4000_3C00)), 32'd1);
        check("pin_tie",       32'(model_argmax(32'h3C00_3C00)), 32'd0);
        check("pin_zeros",     32'(model_argmax(32'h0000_8000)), 32'd0);
        check("pin_nan0",      32'(model_argmax(32'hFC00_7E00)), 32'd1);
        check("pin_nan1",      32'(model_argmax(32'h7E00_3C00)), 32'd0);

        cycle(); cycle();
        reset = 1'b0;
        cycle();
        check("reset_valid", 32'(res_if.result_valid), 32'd0);
        check("reset_class", 32'(res_if.result_class), 32'd0);
        check("reset_busy",  32'(busy), 32'd0);

        run_frame(32'h4000_3C00, 1, "basic");
        run_frame(32'h3C00_3C00, 0, "tie");
        run_frame(32'h0000_8000, 0, "signed_zero");
        run_frame(32'hFC00_7E00, 1, "nan_first");
        run_frame(32'h7E00_3C00, 0, "nan_second");

        // persistence: three human frames then a non-human one
        run_frame(32'h4000_3C00, 1, "human1");
        check("alarm_after_1", 32'(human_alarm), 32'd0);
        run_frame(32'h4000_3C00, 1, "human2");
        check("alarm_after_2", 32'(human_alarm), 32'd0);
        run_frame(32'h4000_3C00, 1, "human3");
        check("alarm_after_3", 32'(human_alarm), 32'd1);
        run_frame(32'h3C00_4000, 0, "nonhuman");
        check("alarm_drop", 32'(human_alarm), 32'd0);

        // overrun while result held, then handshake coinciding with a new edge
        res_if.result_ready = 1'b0;
        fc_data = 32'h4000_3C00; fc_done = 1'b1;
        cycle();
        fc_done = 1'b0;
        for (int i = 0; i < 10 && !res_if.result_valid; i++) cycle();
        fc_data = 32'h3C00_4000; fc_done = 1'b1;
        cycle();
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_class_held", 32'(res_if.result_class), 32'd1);
        fc_done = 1'b0;
        cycle();
        check("ovr_one_cycle", 32'(overrun), 32'd0);
        res_if.result_ready = 1'b1; fc_done = 1'b1;
        cycle();
        check("hs_drop_ovr", 32'(overrun), 32'd1);
        check("hs_drop_idle", 32'(busy), 32'd0);
        fc_done = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("no_second_result", 32'(res_if.result_valid), 32'd0);

        // reset mid-scan with fc_done held high
        fc_data = 32'h4000_3C00; fc_done = 1'b1;
        cycle();
        reset = 1'b1;
        cycle();
        check("rst_mid_valid", 32'(res_if.result_valid), 32'd0);
        check("rst_mid_busy",  32'(busy), 32'd0);
        check("rst_mid_alarm", 32'(human_alarm), 32'd0);
        reset = 1'b0;
        cycle();
        check("rst_recapture", 32'(busy), 32'd1);
        fc_done = 1'b0;
        for (int i = 0; i < 10 && !res_if.result_valid; i++) cycle();
        check("rst_recapture_class", 32'(res_if.result_class), 32'd1);
        cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            fc_data             = {rand_logit(), rand_logit()};
            fc_done             = ($urandom_range(0, 3) == 0);
            res_if.result_ready = ($urandom_range(0, 9) < 6);
            reset               = ($urandom_range(0, 399) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
